// File: rtl/read_data_pkg.sv
// Shared definitions for the load-data alignment/extension unit.
package read_data_pkg;

    localparam int XLEN = 32;

    // LoadType encodings; anything not listed here is an illegal load.
    localparam logic [2:0] LT_WORD   = 3'b000;
    localparam logic [2:0] LT_BYTE_U = 3'b001;
    localparam logic [2:0] LT_BYTE_S = 3'b010;
    localparam logic [2:0] LT_HALF_U = 3'b100;
    localparam logic [2:0] LT_HALF_S = 3'b101;

    // Access size handed to the extender.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } ldSize_t;

endpackage

// File: rtl/read_data_load_extend.sv
// Zero/sign extension of a right-justified byte or halfword to XLEN bits.
module load_extend
    import read_data_pkg::*;
(
    input  logic [XLEN-1:0] field,
    input  ldSize_t         size,
    input  logic            isSigned,
    output logic [XLEN-1:0] result
);

    // Replicate the field's top bit (or zero) into the upper bits.
    always_comb begin
        result = field;
        case (size)
            SZ_BYTE: result = {{(XLEN-8){isSigned & field[7]}}, field[7:0]};
            SZ_HALF: result = {{(XLEN-16){isSigned & field[15]}}, field[15:0]};
            default: result = field;
        endcase
    end

endmodule

// File: rtl/read_data.sv
// Load-data alignment unit: lane select, extend, fault flag, registered copy.
module read_data
    import read_data_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] Addr,
    input  logic [2:0]      LoadType,
    input  logic [XLEN-1:0] ReadData,
    output logic [XLEN-1:0] ReadDataOut,
    output logic            LoadFault,
    output logic [XLEN-1:0] ReadDataOutQ,
    output logic            LoadFaultQ
);

    ldSize_t         size;
    logic            isSigned;
    logic            illegal;
    logic [7:0]      byteSel;
    logic [15:0]     halfSel;
    logic [XLEN-1:0] field;
    logic [XLEN-1:0] extended;
    logic            misaligned;

    // Only the low two address bits matter; the rest is intentionally dropped.
    logic unusedAddr;
    assign unusedAddr = ^Addr[XLEN-1:2];

    // Decode LoadType into size / signedness / illegal.
    always_comb begin
        size     = SZ_WORD;
        isSigned = 1'b0;
        illegal  = 1'b0;
        case (LoadType)
            LT_WORD:   size = SZ_WORD;
            LT_BYTE_U: size = SZ_BYTE;
            LT_BYTE_S: begin size = SZ_BYTE; isSigned = 1'b1; end
            LT_HALF_U: size = SZ_HALF;
            LT_HALF_S: begin size = SZ_HALF; isSigned = 1'b1; end
            default:   illegal = 1'b1;
        endcase
    end

    // Byte/halfword lane mux; Addr[0] is ignored for halfword data.
    always_comb begin
        byteSel = ReadData[7:0];
        case (Addr[1:0])
            2'd0: byteSel = ReadData[7:0];
            2'd1: byteSel = ReadData[15:8];
            2'd2: byteSel = ReadData[23:16];
            2'd3: byteSel = ReadData[31:24];
            default: byteSel = ReadData[7:0];
        endcase
        halfSel = Addr[1] ? ReadData[31:16] : ReadData[15:0];
        case (size)
            SZ_BYTE: field = {{(XLEN-8){1'b0}}, byteSel};
            SZ_HALF: field = {{(XLEN-16){1'b0}}, halfSel};
            default: field = ReadData;
        endcase
    end

    load_extend uExtend (
        .field    (field),
        .size     (size),
        .isSigned (isSigned),
        .result   (extended)
    );

    // Misalignment still yields data; the fault is reported alongside it.
    always_comb begin
        misaligned = ((size == SZ_HALF) && Addr[0]) ||
                     ((size == SZ_WORD) && (Addr[1:0] != 2'd0));
    end

    assign LoadFault   = illegal | misaligned;
    assign ReadDataOut = illegal ? '0 : extended;

    // Unconditional one-cycle copy for pipelined write-back.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ReadDataOutQ <= '0;
            LoadFaultQ   <= 1'b0;
        end else begin
            ReadDataOutQ <= ReadDataOut;
            LoadFaultQ   <= LoadFault;
        end
    end

endmodule

// File: tb/tb_read_data.sv
// Directed self-checking bench for read_data.
module tb_read_data;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Addr;
    logic [2:0]  LoadType;
    logic [31:0] ReadData;
    logic [31:0] ReadDataOut;
    logic        LoadFault;
    logic [31:0] ReadDataOutQ;
    logic        LoadFaultQ;

    int compared   = 0;
    int mismatched = 0;

    read_data dut (
        .clk          (clk),
        .reset        (reset),
        .Addr         (Addr),
        .LoadType     (LoadType),
        .ReadData     (ReadData),
        .ReadDataOut  (ReadDataOut),
        .LoadFault    (LoadFault),
        .ReadDataOutQ (ReadDataOutQ),
        .LoadFaultQ   (LoadFaultQ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [2:0] lt, input logic [31:0] a);
        LoadType = lt;
        Addr     = a;
        #10;
    endtask

    initial begin
        reset    = 1'b1;
        ReadData = 32'ha5b4c3d2;
        LoadType = 3'b000;
        Addr     = 32'h0;
        #12;
        // Registered outputs held clear across edges while reset is high
        chk("rst_q", ReadDataOutQ, 32'h0);
        chk("rst_fq", {31'b0, LoadFaultQ}, 32'h0);
        // Combinational path works during reset
        apply(3'b000, 32'h0);
        chk("lw_a0", ReadDataOut, 32'ha5b4c3d2);
        chk("lw_a0_f", {31'b0, LoadFault}, 32'h0);
        chk("rst_q2", ReadDataOutQ, 32'h0);
        apply(3'b000, 32'h1);
        chk("lw_a1", ReadDataOut, 32'ha5b4c3d2);
        chk("lw_a1_f", {31'b0, LoadFault}, 32'h1);
        apply(3'b000, 32'h2);
        chk("lw_a2_f", {31'b0, LoadFault}, 32'h1);

        reset = 1'b0;
        apply(3'b001, 32'h0); chk("lbu0", ReadDataOut, 32'h000000d2);
        chk("lbu0_f", {31'b0, LoadFault}, 32'h0);
        apply(3'b001, 32'h1); chk("lbu1", ReadDataOut, 32'h000000c3);
        apply(3'b001, 32'h2); chk("lbu2", ReadDataOut, 32'h000000b4);
        apply(3'b001, 32'h3); chk("lbu3", ReadDataOut, 32'h000000a5);
        chk("lbu3_f", {31'b0, LoadFault}, 32'h0);
        apply(3'b001, 32'hfffffff1); chk("lbu_hiaddr", ReadDataOut, 32'h000000c3);

        apply(3'b010, 32'h0); chk("lb0", ReadDataOut, 32'hffffffd2);
        apply(3'b010, 32'h1); chk("lb1", ReadDataOut, 32'hffffffc3);
        apply(3'b010, 32'h2); chk("lb2", ReadDataOut, 32'hffffffb4);
        apply(3'b010, 32'h3); chk("lb3", ReadDataOut, 32'hffffffa5);
        ReadData = 32'h7f7f7f7f;
        apply(3'b010, 32'h0); chk("lb_pos", ReadDataOut, 32'h0000007f);
        ReadData = 32'ha5b4c3d2;

        apply(3'b100, 32'h0); chk("lhu0", ReadDataOut, 32'h0000c3d2);
        apply(3'b100, 32'h2); chk("lhu2", ReadDataOut, 32'h0000a5b4);
        chk("lhu2_f", {31'b0, LoadFault}, 32'h0);
        apply(3'b101, 32'h0); chk("lh0", ReadDataOut, 32'hffffc3d2);
        apply(3'b101, 32'h2); chk("lh2", ReadDataOut, 32'hffffa5b4);
        apply(3'b101, 32'h3); chk("lh3", ReadDataOut, 32'hffffa5b4);
        chk("lh3_f", {31'b0, LoadFault}, 32'h1);
        apply(3'b100, 32'h1); chk("lhu1", ReadDataOut, 32'h0000c3d2);
        chk("lhu1_f", {31'b0, LoadFault}, 32'h1);

        apply(3'b011, 32'h0); chk("ill3", ReadDataOut, 32'h0);
        chk("ill3_f", {31'b0, LoadFault}, 32'h1);
        apply(3'b110, 32'h0); chk("ill6", ReadDataOut, 32'h0);
        chk("ill6_f", {31'b0, LoadFault}, 32'h1);
        apply(3'b111, 32'h2); chk("ill7", ReadDataOut, 32'h0);
        chk("ill7_f", {31'b0, LoadFault}, 32'h1);

        // Registered path: capture one edge later
        @(negedge clk);
        LoadType = 3'b010;
        Addr     = 32'h3;
        @(posedge clk); #1;
        chk("q_lb3", ReadDataOutQ, 32'hffffffa5);
        chk("q_lb3_f", {31'b0, LoadFaultQ}, 32'h0);
        @(negedge clk);
        LoadType = 3'b101;
        Addr     = 32'h1;
        @(posedge clk); #1;
        chk("q_lh1", ReadDataOutQ, 32'hffffc3d2);
        chk("q_lh1_f", {31'b0, LoadFaultQ}, 32'h1);

        // Mid-cycle reset clears Q at once; combinational output untouched
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("q_async_clr", ReadDataOutQ, 32'h0);
        chk("q_async_clr_f", {31'b0, LoadFaultQ}, 32'h0);
        chk("comb_in_rst", ReadDataOut, 32'hffffc3d2);
        @(posedge clk); #1;
        chk("q_hold_rst", ReadDataOutQ, 32'h0);

        // Release between edges: first capture on the next rising edge
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("q_pre_edge", ReadDataOutQ, 32'h0);
        @(posedge clk); #1;
        chk("q_first_cap", ReadDataOutQ, 32'hffffc3d2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
